tex_bilinear_filter: RTL and testbench

Downstream of the texture colour decoder. Accepts one filter request carrying fractional sample coordinates, then consumes the decoded RGBA texels for that sample, one per handshake: four texels for bilinear mode, one for nearest mode. Produces a single filtered RGBA pixel to the shader/output stage over a valid/ready interface.

---
 rtl/tex_bilinear_filter.sv | 177 +++++++++++++++++
 tb/tb_tex_bilinear_filter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_bilinear_filter.sv
// tex_bilinear_filter
// Sits between the texture colour decoder and the shader/output stage.
// A request brings the U/V fractions and the sampling mode. The block then
// takes the texels for that sample, one per handshake:
//   - bilinear mode: four texels, in the order T00, T10, T01, T11
//   - nearest mode:  one texel
// It returns one filtered RGBA pixel. Requests are not pipelined, so only
// one pixel is in flight at any time.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake
//   req_frac_u/v        fractional weights, 0..S-1 where S = 2^FRAC_BITS
//   req_nearest         1 = point sample (single texel, fractions ignored)
//   texel_valid/ready   decoded texel handshake
//   texel_r/g/b/a       decoded texel channels
//   out_valid/ready     filtered pixel handshake
//   out_r/g/b/a         filtered channels, held until the next result loads

module tex_bilinear_filter #(
  parameter int FRAC_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FRAC_BITS-1:0] req_frac_u,
  input  logic [FRAC_BITS-1:0] req_frac_v,
  input  logic                 req_nearest,
  input  logic                 texel_valid,
  output logic                 texel_ready,
  input  logic [7:0]           texel_r,
  input  logic [7:0]           texel_g,
  input  logic [7:0]           texel_b,
  input  logic [7:0]           texel_a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_r,
  output logic [7:0]           out_g,
  output logic [7:0]           out_b,
  output logic [7:0]           out_a
);

  // Width of one weight. The largest weight is S*S, so one bit more than
  // 2*FRAC_BITS is needed.
  localparam int WW = 2*FRAC_BITS + 1;
  // Width of an accumulator. The weights sum to S*S, so the full weighted
  // sum of 8-bit channels fits in 8 + 2*FRAC_BITS bits plus one spare bit.
  localparam int AW = 9 + 2*FRAC_BITS;

  localparam logic [FRAC_BITS:0] S_VAL = {1'b1, {FRAC_BITS{1'b0}}};
  // S*S/2, the constant added for round-half-up before the final shift.
  localparam logic [AW-1:0] HALF =
    {{(AW-2*FRAC_BITS){1'b0}}, 1'b1, {(2*FRAC_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t               state;
  logic [1:0]           count;
  logic [FRAC_BITS-1:0] frac_u;
  logic [FRAC_BITS-1:0] frac_v;
  logic                 nearest;
  logic [AW-1:0]        acc      [4];
  logic [7:0]           pix      [4];
  logic [7:0]           texel_ch [4];
  logic [AW-1:0]        sum      [4];
  logic [7:0]           rounded  [4];
  logic [FRAC_BITS:0]   inv_u;
  logic [FRAC_BITS:0]   inv_v;
  logic [WW-1:0]        mul_a;
  logic [WW-1:0]        mul_b;
  logic [WW-1:0]        weight;

  // The handshake readies depend only on the registered state, so they never
  // depend combinationally on the other side's valid signals.
  assign req_ready   = (state == IDLE);
  assign texel_ready = (state == ACCUM);

  assign out_r = pix[0];
  assign out_g = pix[1];
  assign out_b = pix[2];
  assign out_a = pix[3];

  // Select the weight of the texel that is expected next. The texel order
  // T00, T10, T01, T11 maps count 0..3 onto the four corners, so the weight
  // is a product of either (S-u) or u with either (S-v) or v.
  always_comb begin
    inv_u = S_VAL - {1'b0, frac_u};
    inv_v = S_VAL - {1'b0, frac_v};
    mul_a = '0;
    mul_b = '0;
    case (count)
      2'd0: begin mul_a = WW'(inv_u);  mul_b = WW'(inv_v);  end
      2'd1: begin mul_a = WW'(frac_u); mul_b = WW'(inv_v);  end
      2'd2: begin mul_a = WW'(inv_u);  mul_b = WW'(frac_v); end
      default: begin mul_a = WW'(frac_u); mul_b = WW'(frac_v); end
    endcase
    weight = mul_a * mul_b;
  end

  // For each channel, form the accumulator value that includes the current
  // texel, plus its rounded and normalised 8-bit form. The rounded value is
  // only loaded on the last texel. The result is at most 255, so taking the
  // low byte never wraps.
  always_comb begin
    texel_ch[0] = texel_r;
    texel_ch[1] = texel_g;
    texel_ch[2] = texel_b;
    texel_ch[3] = texel_a;
    for (int c = 0; c < 4; c++) begin
      sum[c]     = acc[c] + AW'(weight) * AW'(texel_ch[c]);
      rounded[c] = 8'((sum[c] + HALF) >> (2*FRAC_BITS));
    end
  end

  // Control FSM and datapath registers.
  // IDLE latches a request and clears the accumulators.
  // ACCUM folds one texel into the accumulators per accepted handshake.
  //   In nearest mode it passes the first texel straight through instead.
  // OUT holds the pixel until the consumer takes it.
  // A reset discards any partial accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      frac_u    <= '0;
      frac_v    <= '0;
      nearest   <= 1'b0;
      out_valid <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        acc[c] <= '0;
        pix[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            frac_u  <= req_frac_u;
            frac_v  <= req_frac_v;
            nearest <= req_nearest;
            count   <= '0;
            for (int c = 0; c < 4; c++) acc[c] <= '0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (texel_valid) begin
            if (nearest) begin
              for (int c = 0; c < 4; c++) pix[c] <= texel_ch[c];
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              for (int c = 0; c < 4; c++) acc[c] <= sum[c];
              count <= count + 2'd1;
              if (count == 2'd3) begin
                for (int c = 0; c < 4; c++) pix[c] <= rounded[c];
                out_valid <= 1'b1;
                state     <= OUT;
              end
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tex_bilinear_filter.sv
// tb_tex_bilinear_filter
// Directed bench for tex_bilinear_filter with FRAC_BITS = 4.
// applyStimulus drives one request and its texels. It pushes the pixel
// predicted by a small reference model onto a scoreboard queue.
// checkOutput pops that prediction when the DUT presents a pixel, compares
// them, and optionally stalls out_ready to check that the output holds.

module tb_tex_bilinear_filter;

  localparam int FRAC_BITS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [FRAC_BITS-1:0] req_frac_u;
  logic [FRAC_BITS-1:0] req_frac_v;
  logic                 req_nearest;
  logic                 texel_valid;
  logic                 texel_ready;
  logic [7:0]           texel_r, texel_g, texel_b, texel_a;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_r, out_g, out_b, out_a;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expq[$];
  logic [31:0] tex [4];

  tex_bilinear_filter #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_frac_u (req_frac_u),
    .req_frac_v (req_frac_v),
    .req_nearest(req_nearest),
    .texel_valid(texel_valid),
    .texel_ready(texel_ready),
    .texel_r    (texel_r),
    .texel_g    (texel_g),
    .texel_b    (texel_b),
    .texel_a    (texel_a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .out_a      (out_a)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case the DUT wedges in a way the bounded waits miss.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge. All driving and
  // sampling happens at this point, away from the edge itself.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model. Each pixel is packed as {r,g,b,a}, with r in the top
  // byte. Weights are (S-u)(S-v), u(S-v), (S-u)v and uv with S = 16.
  // Rounding is half up, then divide by 256.
  function automatic logic [31:0] model(input logic [3:0] u, input logic [3:0] v,
                                        input logic nr, input logic [31:0] t [4]);
    int          w [4];
    int          acc;
    int          uu;
    int          vv;
    logic [31:0] res;
    if (nr) return t[0];
    uu   = int'(u);
    vv   = int'(v);
    w[0] = (16 - uu) * (16 - vv);
    w[1] = uu * (16 - vv);
    w[2] = (16 - uu) * vv;
    w[3] = uu * vv;
    res  = '0;
    for (int c = 0; c < 4; c++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) acc += w[k] * int'(t[k][8*c +: 8]);
      res[8*c +: 8] = 8'((acc + 128) >> 8);
    end
    return res;
  endfunction

  // Send one request and its texels, and push the expected pixel.
  // 'gap' idle cycles with texel_valid low and junk data are inserted
  // between texels.
  task automatic applyStimulus(input logic [3:0] u, input logic [3:0] v,
                               input logic nr, input logic [31:0] t [4],
                               input int gap);
    int n;
    int nt;
    nt = nr ? 1 : 4;
    expq.push_back(model(u, v, nr, t));
    req_frac_u  = u;
    req_frac_v  = v;
    req_nearest = nr;
    req_valid   = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    checkValue("req_ready_wait", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < nt; k++) begin
      texel_valid = 1'b1;
      {texel_r, texel_g, texel_b, texel_a} = t[k];
      n = 0;
      while (!texel_ready && n < 50) begin tick(); n++; end
      checkValue("texel_ready_wait", 32'(texel_ready), 32'd1);
      tick();
      texel_valid = 1'b0;
      {texel_r, texel_g, texel_b, texel_a} = 32'hEEEE_EEEE;
      if (k < nt - 1) repeat (gap) tick();
    end
    checkValue("latency_out_valid", 32'(out_valid), 32'd1);
    checkValue("texel_ready_after_last", 32'(texel_ready), 32'd0);
  endtask

  // Compare the presented pixel against the scoreboard. Then hold out_ready
  // low for 'hold' cycles before accepting the pixel.
  task automatic checkOutput(input int hold);
    int          n;
    logic [31:0] exp;
    logic [31:0] held;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    checkValue("out_valid_wait", 32'(out_valid), 32'd1);
    checkValue("scoreboard_nonempty", 32'(expq.size() != 0), 32'd1);
    exp = (expq.size() != 0) ? expq.pop_front() : 32'h0;
    held = {out_r, out_g, out_b, out_a};
    checkValue("pixel", held, exp);
    repeat (hold) begin
      tick();
      checkValue("hold_out_valid", 32'(out_valid), 32'd1);
      checkValue("hold_pixel_stable", {out_r, out_g, out_b, out_a}, held);
      checkValue("hold_req_ready", 32'(req_ready), 32'd0);
      checkValue("hold_texel_ready", 32'(texel_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkValue("out_valid_drop", 32'(out_valid), 32'd0);
    checkValue("idle_req_ready", 32'(req_ready), 32'd1);
    checkValue("pixel_held_after", {out_r, out_g, out_b, out_a}, held);
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_frac_u  = '0;
    req_frac_v  = '0;
    req_nearest = 1'b0;
    texel_valid = 1'b0;
    {texel_r, texel_g, texel_b, texel_a} = '0;
    out_ready   = 1'b0;

    $display("[TB] reset state");
    tick();
    tick();
    checkValue("rst_out_valid", 32'(out_valid), 32'd0);
    checkValue("rst_req_ready", 32'(req_ready), 32'd1);
    checkValue("rst_texel_ready", 32'(texel_ready), 32'd0);
    checkValue("rst_pixel", {out_r, out_g, out_b, out_a}, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] scenario 1: u=8 v=8 bilinear");
    tex[0] = {8'd0,   8'd10, 8'd20, 8'd30};
    tex[1] = {8'd100, 8'd50, 8'd60, 8'd70};
    tex[2] = {8'd200, 8'd90, 8'd80, 8'd255};
    tex[3] = {8'd44,  8'd1,  8'd2,  8'd3};
    applyStimulus(4'd8, 4'd8, 1'b0, tex, 0);
    checkValue("s1_out_r", 32'(out_r), 32'd86);
    checkOutput(0);

    $display("[TB] scenario 2: u=0 v=0 with texel gaps");
    tex[0] = {8'd17, 8'd34, 8'd51, 8'd68};
    tex[1] = 32'hFFFF_FFFF;
    tex[2] = 32'hFFFF_FFFF;
    tex[3] = 32'hFFFF_FFFF;
    applyStimulus(4'd0, 4'd0, 1'b0, tex, 2);
    checkValue("s2_pixel", {out_r, out_g, out_b, out_a}, 32'h1122_3344);
    checkOutput(0);

    $display("[TB] scenario 3: corner weights and full scale");
    tex[0] = 32'h0;
    tex[1] = 32'h0;
    tex[2] = 32'h0;
    tex[3] = {8'd255, 8'd0, 8'd0, 8'd0};
    applyStimulus(4'd15, 4'd15, 1'b0, tex, 0);
    checkValue("s3_out_r", 32'(out_r), 32'd224);
    checkOutput(0);
    for (int k = 0; k < 4; k++) tex[k] = 32'hFFFF_FFFF;
    applyStimulus(4'd5, 4'd11, 1'b0, tex, 1);
    checkValue("s3_full_scale", {out_r, out_g, out_b, out_a}, 32'hFFFF_FFFF);
    checkOutput(0);

    $display("[TB] scenario 4: nearest");
    tex[0] = {8'd12, 8'd34, 8'd56, 8'd78};
    tex[1] = 32'h0;
    tex[2] = 32'h0;
    tex[3] = 32'h0;
    applyStimulus(4'd7, 4'd3, 1'b1, tex, 0);
    checkValue("s4_pixel", {out_r, out_g, out_b, out_a}, 32'h0C22_384E);
    texel_valid = 1'b1;
    {texel_r, texel_g, texel_b, texel_a} = 32'h9999_9999;
    tick();
    checkValue("s4_no_second_texel", 32'(texel_ready), 32'd0);
    checkValue("s4_pixel_unchanged", {out_r, out_g, out_b, out_a}, 32'h0C22_384E);
    checkOutput(0);
    checkValue("s4_idle_texel_ready", 32'(texel_ready), 32'd0);
    texel_valid = 1'b0;

    $display("[TB] scenario 5: output back-pressure");
    tex[0] = {8'd10, 8'd200, 8'd33, 8'd128};
    tex[1] = {8'd90, 8'd20,  8'd77, 8'd0};
    tex[2] = {8'd250, 8'd5,  8'd1,  8'd64};
    tex[3] = {8'd3,  8'd180, 8'd99, 8'd255};
    applyStimulus(4'd3, 4'd12, 1'b0, tex, 0);
    checkOutput(3);

    $display("[TB] scenario 6: reset mid-accumulation");
    req_frac_u  = 4'd8;
    req_frac_v  = 4'd8;
    req_nearest = 1'b0;
    req_valid   = 1'b1;
    tick();
    req_valid   = 1'b0;
    texel_valid = 1'b1;
    {texel_r, texel_g, texel_b, texel_a} = 32'hFFFF_FFFF;
    tick();
    tick();
    texel_valid = 1'b0;
    rst = 1'b1;
    tick();
    checkValue("s6_rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    checkValue("s6_out_valid", 32'(out_valid), 32'd0);
    checkValue("s6_req_ready", 32'(req_ready), 32'd1);
    checkValue("s6_texel_ready", 32'(texel_ready), 32'd0);
    tex[0] = {8'd0,   8'd10, 8'd20, 8'd30};
    tex[1] = {8'd100, 8'd50, 8'd60, 8'd70};
    tex[2] = {8'd200, 8'd90, 8'd80, 8'd255};
    tex[3] = {8'd44,  8'd1,  8'd2,  8'd3};
    applyStimulus(4'd8, 4'd8, 1'b0, tex, 0);
    checkValue("s6_out_r", 32'(out_r), 32'd86);
    checkOutput(0);

    checkValue("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
